piso_y: RTL

- Parallel-in to serial-out (PISO) converter on the return path of the PE array.
- Captures one row of complex results, one word from each PE, in a single parallel beat. Streams the words out one per cycle on a serial bus with valid/ready backpressure.
- Counts rows so the downstream consumer sees a frame-last marker after ROW_NUM rows.
- Mirror of the Y-input SIPO: that block fans a serial stream out to PEs; this block collects PE outputs back into a stream.

---
 rtl/piso_y.sv | 122 ++++++++++++
 1 files changed

// File: rtl/piso_y.sv
`default_nettype none
// ============================================================================
// piso_y : collects one row of PE results and streams it out word by word
// Rev 1.0
// ============================================================================
module piso_y #(
    parameter int DATA_WIDTH = 16,
    parameter int PE_NUM     = 8,
    parameter int ROW_NUM    = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             p_in_v,
    output logic                             p_in_ready,
    input  logic [PE_NUM*DATA_WIDTH*2-1:0]   p_in,
    output logic                             s_out_v,
    input  logic                             s_out_ready,
    output logic [DATA_WIDTH*2-1:0]          s_out,
    output logic                             s_out_row_last,
    output logic                             s_out_frame_last
);

    localparam int C_WORD_W = DATA_WIDTH * 2;
    localparam int C_ROW_W  = PE_NUM * C_WORD_W;
    localparam int C_WCW    = (PE_NUM  > 1) ? $clog2(PE_NUM)  : 1;
    localparam int C_RCW    = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
    localparam logic [C_WCW-1:0] C_LAST_WORD = C_WCW'(PE_NUM - 1);
    localparam logic [C_RCW-1:0] C_LAST_ROW  = C_RCW'(ROW_NUM - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [C_WCW-1:0]     word_cnt_q, word_cnt_d;
    logic [C_RCW-1:0]     row_cnt_q, row_cnt_d;
    logic [C_ROW_W-1:0]   hold_q, hold_d;
    logic [C_WORD_W-1:0]  s_out_q, s_out_d;
    logic                 s_out_v_q, s_out_v_d;
    logic                 row_last_q, row_last_d;
    logic                 frame_last_q, frame_last_d;

    logic w_accept;
    logic w_consume;

    // Ready looks through s_out_ready on the last word so the next row lands with no bubble
    assign p_in_ready = (state_q == EMPTY) ||
                        ((word_cnt_q == C_LAST_WORD) && s_out_ready);
    assign w_accept   = p_in_v && p_in_ready;
    assign w_consume  = s_out_v_q && s_out_ready;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        row_cnt_d  = row_cnt_q;
        hold_d     = hold_q;

        case (state_q)
            EMPTY: begin
                if (w_accept) begin
                    hold_d     = p_in;
                    word_cnt_d = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (w_consume) begin
                    if (word_cnt_q != C_LAST_WORD) begin
                        word_cnt_d = word_cnt_q + C_WCW'(1);
                    end else begin
                        row_cnt_d  = (row_cnt_q == C_LAST_ROW) ? '0 : row_cnt_q + C_RCW'(1);
                        word_cnt_d = '0;
                        if (p_in_v) begin
                            hold_d = p_in;
                        end else begin
                            state_d = EMPTY;
                        end
                    end
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Outputs are computed from next-state values so they register cleanly
        s_out_v_d    = (state_d == SHIFT);
        s_out_d      = s_out_v_d ? hold_d[int'(word_cnt_d)*C_WORD_W +: C_WORD_W] : '0;
        row_last_d   = s_out_v_d && (word_cnt_d == C_LAST_WORD);
        frame_last_d = row_last_d && (row_cnt_d == C_LAST_ROW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            word_cnt_q   <= '0;
            row_cnt_q    <= '0;
            hold_q       <= '0;
            s_out_q      <= '0;
            s_out_v_q    <= 1'b0;
            row_last_q   <= 1'b0;
            frame_last_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            row_cnt_q    <= row_cnt_d;
            hold_q       <= hold_d;
            s_out_q      <= s_out_d;
            s_out_v_q    <= s_out_v_d;
            row_last_q   <= row_last_d;
            frame_last_q <= frame_last_d;
        end
    end

    assign s_out            = s_out_q;
    assign s_out_v          = s_out_v_q;
    assign s_out_row_last   = row_last_q;
    assign s_out_frame_last = frame_last_q;

endmodule
`default_nettype wire
